// File: rtl/mix_pkg.sv
// Shared MIX definitions: word layout, fetch FSM states and F-spec helpers.
package mix_pkg;

    localparam int unsigned WORD_W   = 31;
    localparam int unsigned BYTE_W   = 6;
    localparam int unsigned SIGN_BIT = 30;
    localparam int unsigned NBYTES   = 5;
    localparam int unsigned MAG_W    = BYTE_W * NBYTES;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_SHIFT
    } state_e;

    // F = 8L+R is usable only when L <= R <= 5.
    function automatic logic field_valid(input logic [5:0] f);
        logic [2:0] l;
        logic [2:0] r;
        l = f[5:3];
        r = f[2:0];
        return (l <= r) && (r <= 3'd5);
    endfunction

    // Number of magnitude bytes in (L:R); the sign position (L=0) carries no byte.
    function automatic logic [2:0] field_nbytes(input logic [2:0] l, input logic [2:0] r);
        logic [2:0] lp;
        lp = (l == 3'd0) ? 3'd1 : l;
        if (r == 3'd0) begin
            return 3'd0;
        end
        return 3'(r - lp + 3'd1);
    endfunction

endpackage

// File: rtl/field_mask.sv
// Combinational field masking of a right-justified word.
//   word   : word already shifted so byte R sits in the low byte
//   l, r   : field bounds
//   result : sign-magnitude field value (sign only kept when L=0)
module field_mask
    import mix_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [2:0]        l,
    input  logic [2:0]        r,
    output logic [WORD_W-1:0] result
);

    logic [2:0]       nb;
    logic [MAG_W-1:0] mask;

    // Keep the low nbytes bytes of the magnitude.
    always_comb begin
        nb   = field_nbytes(l, r);
        mask = '0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            if (3'(i) < nb) begin
                mask[i*BYTE_W +: BYTE_W] = '1;
            end
        end
        result = {(l == 3'd0) ? word[SIGN_BIT] : 1'b0, word[MAG_W-1:0] & mask};
    end

endmodule

// File: rtl/field_fetch.sv
// MIX operand fetch: reads CONTENTS(M) over a req/ack handshake and returns
// the (L:R) field right-justified, with a one-cycle stop pulse.
//   clk, rst_n           : clock, async active-low reset
//   start, addr, field   : operation request, address M, F = 8L+R
//   mem_addr, mem_rd     : memory read request (held until mem_ack)
//   mem_data, mem_ack    : memory read response
//   out, stop, bad_field : field value, completion pulse, invalid-F flag
module field_fetch
    import mix_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [5:0]        field,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [WORD_W-1:0] mem_data,
    input  logic              mem_ack,
    output logic [WORD_W-1:0] out,
    output logic              stop,
    output logic              bad_field
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic              stop_q, stop_d;
    logic              bad_q, bad_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [2:0]        l_q, l_d;
    logic [2:0]        r_q, r_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] masked;

    field_mask u_mask (
        .word   (word_q),
        .l      (l_q),
        .r      (r_q),
        .result (masked)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = mem_rd_q;
        out_d      = out_q;
        stop_d     = 1'b0;
        bad_d      = bad_q;
        word_d     = word_q;
        l_d        = l_q;
        r_d        = r_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mem_addr_d = addr;
                    l_d        = field[5:3];
                    r_d        = field[2:0];
                    if (!field_valid(field)) begin
                        stop_d = 1'b1;
                        bad_d  = 1'b1;
                        out_d  = '0;
                    end else begin
                        bad_d    = 1'b0;
                        mem_rd_d = 1'b1;
                        state_d  = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (mem_ack) begin
                    word_d   = mem_data;
                    mem_rd_d = 1'b0;
                    cnt_d    = 3'(3'd5 - r_q);
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // One byte per cycle until byte R lands in the low byte.
                if (cnt_q != 3'd0) begin
                    word_d = {word_q[SIGN_BIT], word_q[MAG_W-1:0] >> BYTE_W};
                    cnt_d  = cnt_q - 3'd1;
                end else begin
                    out_d   = masked;
                    stop_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            out_q      <= '0;
            stop_q     <= 1'b0;
            bad_q      <= 1'b0;
            word_q     <= '0;
            l_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            out_q      <= out_d;
            stop_q     <= stop_d;
            bad_q      <= bad_d;
            word_q     <= word_d;
            l_q        <= l_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign out       = out_q;
    assign stop      = stop_q;
    assign bad_field = bad_q;

endmodule
